// File: rtl/spi_dac_rx_if.sv
// Bus bundle for the SPI DAC receiver: the three raw SPI pins in, the decoded word and strobes out.
interface spi_dac_rx_if #(
   parameter int unsigned WORD_BITS = 24
);
   logic                 i_spi_sclk;
   logic                 i_spi_sync_n;
   logic                 i_spi_mosi;
   logic [WORD_BITS-1:0] o_word;
   logic                 o_valid;
   logic                 o_frame_err;
   logic                 o_busy;

   modport slave (
      input  i_spi_sclk, i_spi_sync_n, i_spi_mosi,
      output o_word, o_valid, o_frame_err, o_busy
   );

   modport master (
      output i_spi_sclk, i_spi_sync_n, i_spi_mosi,
      input  o_word, o_valid, o_frame_err, o_busy
   );
endinterface

// File: rtl/spi_dac_rx.sv
// SPI slave receiver for a DAC command stream: synchronizes the asynchronous SPI pins into i_clk,
// shifts MSB-first frames of WORD_BITS bits and reports complete words or truncated frames.
module spi_dac_rx #(
   parameter int unsigned WORD_BITS   = 24,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   spi_dac_rx_if.slave  bus
);
   localparam int unsigned      CNT_W    = $clog2(WORD_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] syncn_sync_q, syncn_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   syncn_prev_q, syncn_prev_d;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WORD_BITS-1:0]   shreg_q, shreg_d;
   logic [WORD_BITS-1:0]   word_q, word_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;
   logic                   busy_q, busy_d;

   logic sclk_s, syncn_s, mosi_s;
   logic sclk_fall, syncn_fall, syncn_rise;

   always_comb begin
      sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], bus.i_spi_sclk};
      syncn_sync_d = {syncn_sync_q[SYNC_STAGES-2:0], bus.i_spi_sync_n};
      mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], bus.i_spi_mosi};

      sclk_s  = sclk_sync_q[SYNC_STAGES-1];
      syncn_s = syncn_sync_q[SYNC_STAGES-1];
      mosi_s  = mosi_sync_q[SYNC_STAGES-1];

      sclk_prev_d  = sclk_s;
      syncn_prev_d = syncn_s;

      sclk_fall  = sclk_prev_q & ~sclk_s;
      syncn_fall = syncn_prev_q & ~syncn_s;
      syncn_rise = ~syncn_prev_q & syncn_s;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      word_d  = word_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (syncn_fall) begin
               state_d = SHIFT;
               cnt_d   = '0;
               shreg_d = '0;
            end
         end
         SHIFT: begin
            // A full count is published one cycle after the last shift; a frame end
            // coinciding with that cycle still counts as complete and goes straight to IDLE.
            if (cnt_q == CNT_FULL) begin
               word_d  = shreg_q;
               valid_d = 1'b1;
               state_d = syncn_rise ? IDLE : DONE;
            end else if (syncn_rise) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (sclk_fall) begin
               shreg_d = {shreg_q[WORD_BITS-2:0], mosi_s};
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (syncn_rise) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sclk_sync_q  <= '0;
         syncn_sync_q <= '1;
         mosi_sync_q  <= '0;
         sclk_prev_q  <= 1'b0;
         syncn_prev_q <= 1'b1;
         state_q      <= IDLE;
         cnt_q        <= '0;
         shreg_q      <= '0;
         word_q       <= '0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         sclk_sync_q  <= sclk_sync_d;
         syncn_sync_q <= syncn_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         sclk_prev_q  <= sclk_prev_d;
         syncn_prev_q <= syncn_prev_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shreg_q      <= shreg_d;
         word_q       <= word_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.o_word      = word_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_frame_err = err_q;
   assign bus.o_busy      = busy_q;
endmodule

// File: doc/spi_dac_rx.md
SPI_DAC_RX -- requirements
Module: spi_dac_rx

Interface
REQ-001 Parameter WORD_BITS, default 24, SHALL set the number of bits per frame.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of flip-flops in each input synchronizer (minimum 2).
REQ-003 i_clk  input  1  SHALL be the single clock; all state SHALL be updated on its rising edge.
REQ-004 i_rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 i_spi_sclk  input  1  SHALL be the SPI clock, asynchronous to i_clk; the transmitter changes MOSI on its rising edge.
REQ-006 i_spi_sync_n  input  1  SHALL be the active-low frame select, asynchronous to i_clk.
REQ-007 i_spi_mosi  input  1  SHALL be the serial data input, MSB first, asynchronous to i_clk.
REQ-008 o_word  output  WORD_BITS  SHALL carry the last complete received word.
REQ-009 o_valid  output  1  SHALL be a one-cycle strobe marking an o_word update.
REQ-010 o_frame_err  output  1  SHALL be a one-cycle strobe marking a truncated frame.
REQ-011 o_busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-012 Each of the three SPI inputs SHALL pass through a SYNC_STAGES-deep synchronizer; all logic below SHALL use only the synchronized copies.
REQ-013 Edge detection SHALL compare each synchronized signal with its value registered one cycle earlier.
REQ-014 A sclk falling edge SHALL be detected when the previous value is 1 and the current value is 0.
REQ-015 A sync_n falling edge and a sync_n rising edge SHALL be detected the same way.
REQ-016 MOSI SHALL be sampled from the synchronized copy in the same cycle the sclk falling edge is detected.
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-018 IDLE -> SHIFT SHALL occur on a sync_n falling edge; the bit counter SHALL clear to 0 and the shift register SHALL clear.
REQ-019 In SHIFT, each sclk falling edge SHALL shift {shreg, mosi} in from the LSB side and increment the bit counter.
REQ-020 The bit counter SHALL be $clog2(WORD_BITS+1) bits wide and SHALL NOT wrap.
REQ-021 When the counter reaches WORD_BITS, the FSM SHALL go SHIFT -> DONE.
REQ-022 On that same edge, o_word SHALL load the complete shifted value and o_valid SHALL pulse in the next cycle only.
REQ-023 Pin-to-o_valid latency SHALL be SYNC_STAGES+2 i_clk cycles after the final sclk falling edge at the pin.
REQ-024 In DONE, further sclk edges SHALL be ignored, and o_word SHALL remain stable.
REQ-025 DONE -> IDLE SHALL occur on a sync_n rising edge, with no strobe.
REQ-026 A sync_n rising edge in SHIFT with counter < WORD_BITS SHALL pulse o_frame_err for one cycle and return the FSM to IDLE.
REQ-027 On that truncated-frame event, o_word SHALL be unchanged and o_valid SHALL NOT pulse.
REQ-028 A sclk falling edge and a sync_n rising edge detected in the same cycle SHALL take the sync_n rising edge; the bit SHALL be discarded.
REQ-029 Sclk edges in IDLE SHALL be ignored.
REQ-030 A sync_n falling edge in SHIFT or DONE is impossible without an intervening rising edge and SHALL need no handling.
REQ-031 o_word SHALL hold its value indefinitely between o_valid strobes.
REQ-032 Input timing: every sclk level and every sync_n level SHALL be held at least SYNC_STAGES+1 i_clk cycles; faster input is unsupported.
REQ-033 The block SHALL accept the on-board DAC driver's timing: 20 MHz i_clk, sclk toggling every 11 cycles, sync_n low for 25 sclk periods.

Reset
REQ-034 While i_rst is high, state SHALL be IDLE, and the counter and shift register SHALL be 0.
REQ-035 While i_rst is high, o_word SHALL be 0, and o_valid, o_frame_err and o_busy SHALL be 0.
REQ-036 The sclk synchronizer and its history register SHALL reset to 0.
REQ-037 The sync_n synchronizer and its history register SHALL reset to 1, so that no false frame start is seen at release.
REQ-038 Reset asserted mid-frame SHALL discard the partial frame without any strobe.
REQ-039 After reset release, reception SHALL resume only at the next sync_n falling edge.

Verification
REQ-040 Send 0x007F22 at DAC-driver timing (REQ-033) -> exactly one o_valid, o_word = 0x007F22, o_frame_err never high.
REQ-041 Send 0xFFFFFF, then 0x000000 back-to-back with a 5-period sync_n gap -> two o_valid pulses with o_word 0xFFFFFF then 0x000000, and o_busy low in the gap.
REQ-042 Send 0xA5A5A5 with 25 sclk periods (25th bit = 1) -> o_word = 0xA5A5A5, with the 25th bit ignored.
REQ-043 Raise sync_n after 10 bits of 0x123456, with a prior o_word of 0x007F22 -> one o_frame_err pulse, no o_valid, o_word still 0x007F22.
REQ-044 Assert i_rst after bit 12 of 0xC0FFEE, release, then send 0x00BEEF -> no strobe during reset, o_word = 0 after reset, then o_word = 0x00BEEF with one o_valid.
REQ-045 Toggle sclk 8 times with sync_n high, then send 0x000001 -> only one o_valid, o_word = 0x000001.
